// File: rtl/mac_acc_if.sv
// mac_acc_if -- sample/result bundle for the mac_acc multiply-accumulator.
//
// Parameters match mac_acc: AW/BW signed operand widths, PW result width.
//
// Signals:
//   in_valid   qualifies ain/bin/cin on the current edge
//   ain, bin   signed operands
//   cin        signed preload, consumed only by the first sample of a frame
//   acout      ain delayed two edges (cascade output)
//   pout       signed frame result, held between pulses
//   out_valid  one-cycle pulse when pout carries a new result
//   ovf        sticky saturation flag (always 0 unless saturation is built in)
//
// Modports: master drives samples and observes results; slave is the MAC.

interface mac_acc_if #(
    parameter int AW = 27,
    parameter int BW = 18,
    parameter int PW = 48
);

    logic                 in_valid;
    logic signed [AW-1:0] ain;
    logic signed [BW-1:0] bin;
    logic signed [PW-1:0] cin;
    logic signed [AW-1:0] acout;
    logic signed [PW-1:0] pout;
    logic                 out_valid;
    logic                 ovf;

    modport master (
        output in_valid, ain, bin, cin,
        input  acout, pout, out_valid, ovf
    );

    modport slave (
        input  in_valid, ain, bin, cin,
        output acout, pout, out_valid, ovf
    );

endinterface

// File: rtl/mac_acc.sv
// mac_acc -- pipelined signed multiply-accumulator producing one result per NACC products.
//
// Pipeline:
//   S1  register ain/bin/cin/valid
//   S2  register again
//   S3  mreg = ain * bin at full AW+BW width, sign-extended to PW
//   S4  acc = (first sample of frame ? cin : acc) + mreg; frame counter advances
//   S5  pout/out_valid register the completed frame
// out_valid is high in the cycle after the 4th rising edge following the edge that
// sampled the last in_valid of a frame. Bubbles (in_valid low) flow down the pipe and
// leave acc and the frame counter untouched.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, priority over in_valid
//   bus   mac_acc_if.slave (in_valid, ain, bin, cin -> acout, pout, out_valid, ovf)
//
// Build option:
//   MAC_ACC_SAT_EN  when defined, S4 adds with one guard bit and clamps to the PW-bit
//                   signed range; ovf latches on any clamp until rst. When undefined,
//                   arithmetic wraps modulo 2^PW and ovf is tied low.

module mac_acc #(
    parameter int AW   = 27,
    parameter int BW   = 18,
    parameter int PW   = 48,
    parameter int NACC = 16
) (
    input logic     clk,
    input logic     rst,
    mac_acc_if.slave bus
);

    // NACC = 1 still needs a one-bit counter so the compare below stays well formed.
    localparam int              CW       = (NACC > 1) ? $clog2(NACC) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(NACC - 1);

    // Local copies of the interface inputs.
    logic                 in_valid;
    logic signed [AW-1:0] ain;
    logic signed [BW-1:0] bin;
    logic signed [PW-1:0] cin;

    assign in_valid = bus.in_valid;
    assign ain      = bus.ain;
    assign bin      = bus.bin;
    assign cin      = bus.cin;

    // S1 / S2 operand stages. Data loads every cycle: acout must follow ain regardless
    // of in_valid, and the valid bits alone decide whether a product is accumulated.
    logic                 v1, v2;
    logic signed [AW-1:0] a1, a2;
    logic signed [BW-1:0] b1, b2;
    logic signed [PW-1:0] c1, c2;

    // S3 product stage; cin rides along so it meets its own product in S4.
    logic                    v3;
    logic signed [AW+BW-1:0] prod;
    logic signed [PW-1:0]    mreg;
    logic signed [PW-1:0]    c3;

    // S4 accumulator and frame counter (counts k-1, so 0 marks the first sample).
    logic signed [PW-1:0] acc;
    logic signed [PW-1:0] acc_base;
    logic signed [PW-1:0] sum;
    logic [CW-1:0]        cnt;
    logic                 frame_done;

    // S5 result register.
    logic signed [PW-1:0] pout_q;
    logic                 out_valid_q;

    assign prod = a2 * b2;

    always_comb begin
        acc_base = acc;
        if (cnt == '0) begin
            acc_base = c3;
        end
    end

`ifdef MAC_ACC_SAT_EN
    localparam logic signed [PW-1:0] SAT_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {1'b1, {(PW-1){1'b0}}};

    logic signed [PW:0] sum_wide;
    logic               clamp;
    logic               ovf_q;

    // One guard bit is enough: the sum of two PW-bit values always fits in PW+1 bits.
    assign sum_wide = {acc_base[PW-1], acc_base} + {mreg[PW-1], mreg};
    assign clamp    = sum_wide[PW] ^ sum_wide[PW-1];

    always_comb begin
        sum = sum_wide[PW-1:0];
        if (clamp) begin
            sum = sum_wide[PW] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (v3 && clamp) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign sum     = acc_base + mreg;
    assign bus.ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            a1          <= '0;
            a2          <= '0;
            b1          <= '0;
            b2          <= '0;
            c1          <= '0;
            c2          <= '0;
            c3          <= '0;
            mreg        <= '0;
            acc         <= '0;
            cnt         <= '0;
            frame_done  <= 1'b0;
            pout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // S1
            v1 <= in_valid;
            a1 <= ain;
            b1 <= bin;
            c1 <= cin;
            // S2
            v2 <= v1;
            a2 <= a1;
            b2 <= b1;
            c2 <= c1;
            // S3
            v3   <= v2;
            mreg <= PW'(prod);
            c3   <= c2;
            // S4: only valid products touch acc and the counter.
            if (v3) begin
                acc <= sum;
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
            frame_done <= v3 && (cnt == CNT_LAST);
            // S5
            out_valid_q <= frame_done;
            if (frame_done) begin
                pout_q <= acc;
            end
        end
    end

    assign bus.acout     = a2;
    assign bus.pout      = pout_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_acc.sv
// tb_mac_acc -- directed self-checking bench for mac_acc.
//
// Three instances:
//   dut_m  AW=27 BW=18 PW=48 NACC=4  main frame, bubble, back-to-back, reset, acout tests
//   dut_s  AW=8  BW=8  PW=16 NACC=4  saturation / wraparound
//   dut_1  AW=8  BW=8  PW=20 NACC=1  single-product frames
// Expected saturation results follow MAC_ACC_SAT_EN as seen by this compile.

module tb_mac_acc;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mac_acc_if #(.AW(27), .BW(18), .PW(48)) bm ();
    mac_acc_if #(.AW(8),  .BW(8),  .PW(16)) bs ();
    mac_acc_if #(.AW(8),  .BW(8),  .PW(20)) b1 ();

    mac_acc #(.AW(27), .BW(18), .PW(48), .NACC(4)) dut_m (.clk(clk), .rst(rst), .bus(bm));
    mac_acc #(.AW(8),  .BW(8),  .PW(16), .NACC(4)) dut_s (.clk(clk), .rst(rst), .bus(bs));
    mac_acc #(.AW(8),  .BW(8),  .PW(20), .NACC(1)) dut_1 (.clk(clk), .rst(rst), .bus(b1));

    int n_checks = 0;
    int n_fail   = 0;

    // Rising edges seen so far; read on falling edges only.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log for dut_m.
    int                 pulse_cyc[$];
    logic signed [47:0] pulse_val[$];
    always @(negedge clk) begin
        if (bm.out_valid === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pulse_val.push_back(bm.pout);
        end
    end

    int last_m;

    task automatic drive_m(input logic v, input logic signed [26:0] a,
                           input logic signed [17:0] b, input logic signed [47:0] c);
        @(negedge clk);
        bm.in_valid = v;
        bm.ain      = a;
        bm.bin      = b;
        bm.cin      = c;
        last_m      = cyc;
    endtask

    task automatic drive_s(input logic v, input logic signed [7:0] a,
                           input logic signed [7:0] b, input logic signed [15:0] c);
        @(negedge clk);
        bs.in_valid = v;
        bs.ain      = a;
        bs.bin      = b;
        bs.cin      = c;
    endtask

    // Idle dut_s for n cycles, counting pulses and keeping the last result seen.
    task automatic collect_s(input int n, output int cnt, output logic signed [15:0] val);
        cnt = 0;
        val = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bs.in_valid = 1'b0;
            if (bs.out_valid === 1'b1) begin
                cnt++;
                val = bs.pout;
            end
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bm.in_valid = 1'b1;
        bm.ain      = 27'sd55;
        bm.bin      = 18'sd3;
        bm.cin      = 48'sd7;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bm.out_valid !== 1'b0 || bm.pout !== 48'sd0) begin
            n_fail++;
            $display("FAIL reset_m_out: out_valid=%b pout=%0d, want 0/0", bm.out_valid, bm.pout);
        end
        n_checks++;
        if (bm.acout !== 27'sd0 || bm.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_m_misc: acout=%0d ovf=%b, want 0/0", bm.acout, bm.ovf);
        end
        n_checks++;
        if (bs.out_valid !== 1'b0 || bs.pout !== 16'sd0 || bs.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_s: out_valid=%b pout=%0d ovf=%b, want 0/0/0",
                     bs.out_valid, bs.pout, bs.ovf);
        end
        n_checks++;
        if (b1.out_valid !== 1'b0 || b1.pout !== 20'sd0) begin
            n_fail++;
            $display("FAIL reset_1: out_valid=%b pout=%0d, want 0/0", b1.out_valid, b1.pout);
        end
        @(negedge clk);
        rst         = 1'b0;
        bm.in_valid = 1'b0;
    endtask

    task automatic test_contiguous();
        int base = pulse_cyc.size();
        int t_last;
        drive_m(1'b1, 27'sd1, 18'sd2, 48'sd10);
        drive_m(1'b1, 27'sd2, 18'sd2, 48'sd10);
        drive_m(1'b1, 27'sd3, 18'sd2, 48'sd10);
        drive_m(1'b1, 27'sd4, 18'sd2, 48'sd10);
        t_last = last_m;
        repeat (8) drive_m(1'b0, 27'sd0, 18'sd0, 48'sd0);
        n_checks++;
        if (pulse_cyc.size() != base + 1) begin
            n_fail++;
            $display("FAIL contig_pulses: got %0d pulses, want 1", pulse_cyc.size() - base);
        end
        if (pulse_cyc.size() > base) begin
            n_checks++;
            if (pulse_cyc[base] != t_last + 5) begin
                n_fail++;
                $display("FAIL contig_latency: pulse at %0d, want %0d", pulse_cyc[base], t_last + 5);
            end
            n_checks++;
            if (pulse_val[base] !== 48'sd30) begin
                n_fail++;
                $display("FAIL contig_value: pout=%0d, want 30", pulse_val[base]);
            end
        end
        n_checks++;
        if (bm.pout !== 48'sd30 || bm.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL contig_hold: pout=%0d out_valid=%b, want 30/0", bm.pout, bm.out_valid);
        end
    endtask

    task automatic test_bubbles();
        int base = pulse_cyc.size();
        int t_first;
        drive_m(1'b1, 27'sd1, 18'sd2, 48'sd10);
        t_first = last_m;
        drive_m(1'b1, 27'sd2, 18'sd2, 48'sd10);
        repeat (3) drive_m(1'b0, 27'sd50, 18'sd50, 48'sd50);
        drive_m(1'b1, 27'sd3, 18'sd2, 48'sd10);
        drive_m(1'b1, 27'sd4, 18'sd2, 48'sd10);
        repeat (9) drive_m(1'b0, 27'sd0, 18'sd0, 48'sd0);
        n_checks++;
        if (pulse_cyc.size() != base + 1) begin
            n_fail++;
            $display("FAIL bubble_pulses: got %0d pulses, want 1", pulse_cyc.size() - base);
        end
        if (pulse_cyc.size() > base) begin
            n_checks++;
            if (pulse_cyc[base] != t_first + 11) begin
                n_fail++;
                $display("FAIL bubble_latency: pulse at %0d, want %0d",
                         pulse_cyc[base], t_first + 11);
            end
            n_checks++;
            if (pulse_val[base] !== 48'sd30) begin
                n_fail++;
                $display("FAIL bubble_value: pout=%0d, want 30", pulse_val[base]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base = pulse_cyc.size();
        int t_first;
        // cin on k>1 samples is junk and must be ignored.
        drive_m(1'b1, 27'sd1, 18'sd1, 48'sd0);
        t_first = last_m;
        drive_m(1'b1, 27'sd1, 18'sd1, 48'sd999);
        drive_m(1'b1, 27'sd1, 18'sd1, 48'sd999);
        drive_m(1'b1, 27'sd1, 18'sd1, 48'sd999);
        drive_m(1'b1, -27'sd1, 18'sd3, 48'sd100);
        drive_m(1'b1, -27'sd1, 18'sd3, 48'sd999);
        drive_m(1'b1, -27'sd1, 18'sd3, 48'sd999);
        drive_m(1'b1, -27'sd1, 18'sd3, 48'sd999);
        repeat (8) drive_m(1'b0, 27'sd0, 18'sd0, 48'sd0);
        n_checks++;
        if (pulse_cyc.size() != base + 2) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d pulses, want 2", pulse_cyc.size() - base);
        end
        if (pulse_cyc.size() >= base + 2) begin
            n_checks++;
            if (pulse_cyc[base] != t_first + 8 || pulse_cyc[base+1] != t_first + 12) begin
                n_fail++;
                $display("FAIL b2b_timing: pulses at %0d,%0d, want %0d,%0d", pulse_cyc[base],
                         pulse_cyc[base+1], t_first + 8, t_first + 12);
            end
            n_checks++;
            if (pulse_val[base] !== 48'sd4 || pulse_val[base+1] !== 48'sd88) begin
                n_fail++;
                $display("FAIL b2b_values: pout=%0d,%0d, want 4,88",
                         pulse_val[base], pulse_val[base+1]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int base = pulse_cyc.size();
        int t_last;
        drive_m(1'b1, 27'sd7, 18'sd7, 48'sd3);
        drive_m(1'b1, 27'sd7, 18'sd7, 48'sd3);
        // Valid sample presented on the reset edge must be dropped.
        drive_m(1'b1, 27'sd9, 18'sd9, 48'sd9);
        rst = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        bm.in_valid = 1'b0;
        n_checks++;
        if (bm.pout !== 48'sd0 || bm.acout !== 27'sd0) begin
            n_fail++;
            $display("FAIL abort_cleared: pout=%0d acout=%0d, want 0/0", bm.pout, bm.acout);
        end
        repeat (4) drive_m(1'b1, 27'sd5, 18'sd5, 48'sd0);
        t_last = last_m;
        repeat (8) drive_m(1'b0, 27'sd0, 18'sd0, 48'sd0);
        n_checks++;
        if (pulse_cyc.size() != base + 1) begin
            n_fail++;
            $display("FAIL abort_pulses: got %0d pulses, want 1", pulse_cyc.size() - base);
        end
        if (pulse_cyc.size() > base) begin
            n_checks++;
            if (pulse_val[base] !== 48'sd100 || pulse_cyc[base] != t_last + 5) begin
                n_fail++;
                $display("FAIL abort_value: pout=%0d at %0d, want 100 at %0d",
                         pulse_val[base], pulse_cyc[base], t_last + 5);
            end
        end
    endtask

    task automatic test_saturation();
        int                 cnt;
        logic signed [15:0] val;
        logic signed [15:0] exp_pos, exp_neg;
        logic               exp_ovf;
`ifdef MAC_ACC_SAT_EN
        exp_pos = 16'sd32767;
        exp_neg = -16'sd32768;
        exp_ovf = 1'b1;
`else
        exp_pos = 16'sd31747;
        exp_neg = -16'sd32256;
        exp_ovf = 1'b0;
`endif
        drive_s(1'b1, 8'sd127, 8'sd127, 16'sd32767);
        repeat (3) drive_s(1'b1, 8'sd127, 8'sd127, 16'sd0);
        collect_s(8, cnt, val);
        n_checks++;
        if (cnt != 1 || val !== exp_pos || bs.ovf !== exp_ovf) begin
            n_fail++;
            $display("FAIL sat_pos: pulses=%0d pout=%0d ovf=%b, want 1/%0d/%b",
                     cnt, val, bs.ovf, exp_pos, exp_ovf);
        end
        drive_s(1'b1, -8'sd128, 8'sd127, -16'sd32768);
        repeat (3) drive_s(1'b1, -8'sd128, 8'sd127, 16'sd0);
        collect_s(8, cnt, val);
        n_checks++;
        if (cnt != 1 || val !== exp_neg || bs.ovf !== exp_ovf) begin
            n_fail++;
            $display("FAIL sat_neg: pulses=%0d pout=%0d ovf=%b, want 1/%0d/%b",
                     cnt, val, bs.ovf, exp_neg, exp_ovf);
        end
        // Non-clamping frame: result exact, ovf stays as it was.
        drive_s(1'b1, 8'sd1, 8'sd1, 16'sd0);
        repeat (3) drive_s(1'b1, 8'sd1, 8'sd1, 16'sd0);
        collect_s(8, cnt, val);
        n_checks++;
        if (cnt != 1 || val !== 16'sd4 || bs.ovf !== exp_ovf) begin
            n_fail++;
            $display("FAIL sat_sticky: pulses=%0d pout=%0d ovf=%b, want 1/4/%b",
                     cnt, val, bs.ovf, exp_ovf);
        end
    endtask

    task automatic test_nacc1();
        logic signed [19:0] got[3];
        logic signed [19:0] exp_v[3];
        int                 cnt = 0;
        exp_v[0] = -20'sd7;
        exp_v[1] = 20'sd0;
        exp_v[2] = 20'sd17129;
        got[0] = '0;
        got[1] = '0;
        got[2] = '0;
        @(negedge clk);
        b1.in_valid = 1'b1; b1.ain = 8'sd3;   b1.bin = -8'sd4;  b1.cin = 20'sd5;
        @(negedge clk);
        b1.in_valid = 1'b1; b1.ain = -8'sd10; b1.bin = -8'sd10; b1.cin = -20'sd100;
        @(negedge clk);
        b1.in_valid = 1'b1; b1.ain = 8'sd127; b1.bin = 8'sd127; b1.cin = 20'sd1000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b1.in_valid = 1'b0;
            if (b1.out_valid === 1'b1) begin
                if (cnt < 3) got[cnt] = b1.pout;
                cnt++;
            end
        end
        n_checks++;
        if (cnt != 3) begin
            n_fail++;
            $display("FAIL nacc1_pulses: got %0d pulses, want 3", cnt);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (got[i] !== exp_v[i]) begin
                n_fail++;
                $display("FAIL nacc1_value%0d: pout=%0d, want %0d", i, got[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_acout();
        logic [26:0] hist[$];
        logic [26:0] a;
        int          bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                n_checks++;
                if (bm.acout !== hist[i-2]) begin
                    n_fail++;
                    bad++;
                    if (bad <= 5)
                        $display("FAIL acout_delay[%0d]: acout=%0h, want %0h",
                                 i, bm.acout, hist[i-2]);
                end
            end
            a = 27'($urandom);
            hist.push_back(a);
            bm.ain      = a;
            bm.in_valid = 1'($urandom_range(0, 1));
            bm.bin      = 18'($urandom);
            bm.cin      = 48'($urandom);
        end
        @(negedge clk);
        bm.in_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bm.in_valid = 1'b0; bm.ain = '0; bm.bin = '0; bm.cin = '0;
        bs.in_valid = 1'b0; bs.ain = '0; bs.bin = '0; bs.cin = '0;
        b1.in_valid = 1'b0; b1.ain = '0; b1.bin = '0; b1.cin = '0;
        test_reset();
        test_contiguous();
        test_bubbles();
        test_back_to_back();
        test_reset_abort();
        test_saturation();
        test_nacc1();
        test_acout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_acc.md
MAC_ACC -- requirements
Module: mac_acc

Interface
REQ-001 SHALL have parameter AW, default 27, signed A operand width.
REQ-002 SHALL have parameter BW, default 18, signed B operand width.
REQ-003 SHALL have parameter PW, default 48, signed accumulator/result width; PW >= AW+BW.
REQ-004 SHALL have parameter NACC, default 16, products per frame; NACC >= 1.
REQ-005 SHALL have a single clock and a synchronous, active-high reset; no other clock or reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  ain/bin/cin qualify on this edge.
REQ-009 ain  input  AW  signed A operand.
REQ-010 bin  input  BW  signed B operand.
REQ-011 cin  input  PW  signed preload, used only on the first sample of a frame.
REQ-012 acout  output  AW  ain delayed two clocks, unconditional cascade.
REQ-013 pout  output  PW  signed frame result.
REQ-014 out_valid  output  1  one-cycle pulse when pout carries a new result.
REQ-015 ovf  output  1  sticky saturation flag (see Configuration).

Function
REQ-016 Pipeline: S1 registers ain/bin/cin/valid; S2 registers again; S3 mreg = S2 ain * S2 bin at full AW+BW width, sign-extended to PW; S4 accumulates.
REQ-017 Accepted sample k (1..NACC) of a frame: k=1 -> acc = cin + mreg; k>1 -> acc = acc + mreg; cin travels with its sample.
REQ-018 Frame counter counts valid products entering S4 and wraps NACC -> 1.
REQ-019 On the edge completing the NACC-th product, pout <= new acc and out_valid = 1 for exactly one cycle.
REQ-020 Latency: out_valid high in the cycle after the 4th rising edge following the edge that sampled the NACC-th in_valid.
REQ-021 in_valid low inserts a bubble that propagates down the pipe; acc and counter hold on bubbles; frame gaps are unlimited.
REQ-022 Back-to-back frames with no gap are fully supported at one sample per clock; the first sample of the next frame lands on the edge after the previous frame's last.
REQ-023 pout holds the last result between out_valid pulses.
REQ-024 Without saturation, arithmetic is two's-complement modulo 2^PW.
REQ-025 acout = ain delayed exactly two edges, independent of in_valid.
REQ-026 NACC = 1: every valid sample produces pout = cin + ain*bin.

Reset
REQ-027 rst SHALL clear all pipeline data and valids, mreg, acc, counter, acout, pout, out_valid and ovf to 0 on the next edge.
REQ-028 A partial frame in flight at reset SHALL be discarded; the first valid sample after rst deasserts starts a new frame with k=1.
REQ-029 rst SHALL take priority over in_valid on the same edge.

Configuration
REQ-030 Macro MAC_ACC_SAT_EN defined: S4 computes with one guard bit; results above 2^(PW-1)-1 or below -2^(PW-1) clamp to that bound; ovf sets on any clamp and clears only on rst.
REQ-031 MAC_ACC_SAT_EN undefined: modulo arithmetic per REQ-024; ovf tied to 0; no guard bit logic.

Verification
REQ-032 NACC=4, cin=10, bin=2, ain=1,2,3,4 contiguous -> one out_valid pulse with pout=30, 4 edges after the 4th sample.
REQ-033 Same stimulus with in_valid low for 3 cycles between samples 2 and 3 -> pout=30, pulse delayed by 3 cycles, no extra pulses.
REQ-034 Two contiguous NACC=4 frames (cin=0, ain=1, bin=1; then cin=100, ain=-1, bin=3) -> pulses 4 cycles apart, pout=4 then pout=88.
REQ-035 rst pulsed after sample 2 of a frame, then 4 fresh samples ain=5, bin=5, cin=0 -> no pulse for the aborted frame, next pout=100.
REQ-036 AW=8, BW=8, PW=16, NACC=4, cin=32767, ain=127, bin=127: with MAC_ACC_SAT_EN -> pout=32767, ovf=1; without -> pout=(32767+64516) mod 2^16 as signed, ovf=0.
REQ-037 Random ain sequence, in_valid random -> acout equals ain from two edges earlier on every cycle.
